// File: rtl/aes_cbc_decrypt_dev.sv
// aes_cbc_decrypt_dev: iterative AES-128 CBC decryption peripheral on NOC16.
// One inverse round per clock; round keys and IV are host-loaded in 64-bit chunks.
// Optional build macro AES_DEC_ERR_EN adds the sticky err_syndrome output.
module aes_cbc_decrypt_dev #(
    parameter logic [7:0] OUT_CMD = 8'hFE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] Ksubs3_Noc16_RxData_lo,
    input  logic [7:0]  Ksubs3_Noc16_RxData_cmd,
    input  logic        Ksubs3_Noc16_RxData_valid,
    output logic        Ksubs3_Noc16_RxData_rdy,
    output logic [63:0] Ksubs3_Noc16_TxData_lo,
    output logic [7:0]  Ksubs3_Noc16_TxData_cmd,
    output logic        Ksubs3_Noc16_TxData_valid,
    input  logic        Ksubs3_Noc16_TxData_rdy,
    output logic        busy
`ifdef AES_DEC_ERR_EN
    ,
    output logic [7:0]  err_syndrome
`endif
);

    localparam int ROUNDS = 10;
    localparam logic [3:0] FIRST_RND = 4'(ROUNDS - 1);

    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {IDLE, ROUND, TX_LO, TX_HI} fsm_t;

    fsm_t           fsm;
    logic [1407:0]  rk;
    logic [127:0]   iv;
    logic [127:0]   ct;
    logic [127:0]   st;
    logic [4:0]     rk_idx;
    logic           iv_idx;
    logic [1:0]     ct_cnt;
    logic [3:0]     rnd;

    logic [127:0]   inv_sr;
    logic [127:0]   inv_sb;
    logic [127:0]   round_key;
    logic [127:0]   ark;
    logic [127:0]   inv_mc;
    logic [127:0]   pt;
    logic           rx_accept;
    logic           tx_accept;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] b  [4];
        logic [7:0] m2 [4];
        logic [7:0] m4 [4];
        logic [7:0] m8 [4];
        logic [31:0] o;
        for (int unsigned k = 0; k < 4; k++) begin
            b[k]  = w[8*k +: 8];
            m2[k] = xt(b[k]);
            m4[k] = xt(m2[k]);
            m8[k] = xt(m4[k]);
        end
        o = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            o[8*k +: 8] = (m8[k] ^ m4[k] ^ m2[k])
                        ^ (m8[(k+1)%4] ^ m2[(k+1)%4] ^ b[(k+1)%4])
                        ^ (m8[(k+2)%4] ^ m4[(k+2)%4] ^ b[(k+2)%4])
                        ^ (m8[(k+3)%4] ^ b[(k+3)%4]);
        end
        return o;
    endfunction

    assign rx_accept = Ksubs3_Noc16_RxData_valid && Ksubs3_Noc16_RxData_rdy;
    assign tx_accept = Ksubs3_Noc16_TxData_valid && Ksubs3_Noc16_TxData_rdy;
    assign round_key = rk[{rnd, 7'b0} +: 128];

    // One inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns
    always_comb begin
        inv_sr = '0;
        inv_sb = '0;
        inv_mc = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                inv_sr[32*j + 8*k +: 8] = st[32*((j + 4 - k) % 4) + 8*k +: 8];
            end
        end
        for (int unsigned i = 0; i < 16; i++) begin
            inv_sb[8*i +: 8] = INV_SBOX[inv_sr[8*i +: 8]];
        end
        ark = inv_sb ^ round_key;
        for (int unsigned j = 0; j < 4; j++) begin
            inv_mc[32*j +: 32] = inv_mix_word(ark[32*j +: 32]);
        end
        pt = ark ^ iv;
    end

    // Control FSM, host-side loading and registered NOC outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm                       <= IDLE;
            rk                        <= '0;
            iv                        <= '0;
            ct                        <= '0;
            st                        <= '0;
            rk_idx                    <= '0;
            iv_idx                    <= 1'b0;
            ct_cnt                    <= '0;
            rnd                       <= '0;
            busy                      <= 1'b0;
            Ksubs3_Noc16_RxData_rdy   <= 1'b0;
            Ksubs3_Noc16_TxData_lo    <= '0;
            Ksubs3_Noc16_TxData_cmd   <= '0;
            Ksubs3_Noc16_TxData_valid <= 1'b0;
`ifdef AES_DEC_ERR_EN
            err_syndrome              <= '0;
`endif
        end else begin
            case (fsm)
                IDLE: begin
                    if (ct_cnt == 2'd2) begin
                        st                      <= ct ^ rk[ROUNDS*128 +: 128];
                        rnd                     <= FIRST_RND;
                        busy                    <= 1'b1;
                        fsm                     <= ROUND;
                        Ksubs3_Noc16_RxData_rdy <= 1'b0;
                    end else begin
                        Ksubs3_Noc16_RxData_rdy <= 1'b1;
                        if (rx_accept) begin
                            case (Ksubs3_Noc16_RxData_cmd)
                                8'd0: begin
                                    rk[{rk_idx, 6'b0} +: 64] <= Ksubs3_Noc16_RxData_lo;
                                    rk_idx <= (rk_idx == 5'd21) ? 5'd0 : rk_idx + 5'd1;
                                end
                                8'd1: begin
                                    iv[{iv_idx, 6'b0} +: 64] <= Ksubs3_Noc16_RxData_lo;
                                    iv_idx <= ~iv_idx;
                                end
                                8'd2: begin
                                    ct[{ct_cnt[0], 6'b0} +: 64] <= Ksubs3_Noc16_RxData_lo;
                                    ct_cnt <= ct_cnt + 2'd1;
                                    if (ct_cnt == 2'd1) begin
                                        Ksubs3_Noc16_RxData_rdy <= 1'b0;
                                    end
                                end
                                default: begin
`ifdef AES_DEC_ERR_EN
                                    err_syndrome <= Ksubs3_Noc16_RxData_cmd;
`endif
                                end
                            endcase
                        end
                    end
                end
                ROUND: begin
                    if (rnd != 4'd0) begin
                        st  <= inv_mc;
                        rnd <= rnd - 4'd1;
                    end else begin
                        // plaintext kept in st so TX_HI can send the upper half
                        st                        <= pt;
                        iv                        <= ct;
                        Ksubs3_Noc16_TxData_lo    <= pt[63:0];
                        Ksubs3_Noc16_TxData_cmd   <= OUT_CMD;
                        Ksubs3_Noc16_TxData_valid <= 1'b1;
                        fsm                       <= TX_LO;
                    end
                end
                TX_LO: begin
                    if (tx_accept) begin
                        Ksubs3_Noc16_TxData_lo <= st[127:64];
                        fsm                    <= TX_HI;
                    end
                end
                TX_HI: begin
                    if (tx_accept) begin
                        Ksubs3_Noc16_TxData_valid <= 1'b0;
                        Ksubs3_Noc16_TxData_cmd   <= '0;
                        busy                      <= 1'b0;
                        ct_cnt                    <= '0;
                        Ksubs3_Noc16_RxData_rdy   <= 1'b1;
                        fsm                       <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_cbc_decrypt_dev.sv
// Scoreboard bench for aes_cbc_decrypt_dev: stimulus pushes expected plaintext
// beats; an independent monitor pops and compares on every accepted Tx beat.
module tb_aes_cbc_decrypt_dev;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rx_lo = '0;
    logic [7:0]  rx_cmd = '0;
    logic        rx_valid = 1'b0;
    logic        rx_rdy;
    logic [63:0] tx_lo;
    logic [7:0]  tx_cmd;
    logic        tx_valid;
    logic        tx_rdy = 1'b1;
    logic        busy;
`ifdef AES_DEC_ERR_EN
    logic [7:0]  err_syndrome;
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q [$];

    localparam logic [63:0] CT_LO  = 64'h30047b6ad8e0c469;
    localparam logic [63:0] CT_HI  = 64'h5ac5b47080b7cdd8;
    localparam logic [63:0] PT_LO  = 64'h7766554433221100;
    localparam logic [63:0] PT_HI  = 64'hffeeddccbbaa9988;
    localparam logic [63:0] CH_LO  = 64'h47622e2eebc2d569;
    localparam logic [63:0] CH_HI  = 64'ha52b69bc3b1d5450;

    // FIPS-197 expanded key for 000102..0f, written in FIPS byte order
    localparam logic [127:0] KEY_FIPS [11] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe,
        128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd,
        128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b,
        128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2,
        128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    aes_cbc_decrypt_dev #(.OUT_CMD(8'hFE)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .Ksubs3_Noc16_RxData_lo    (rx_lo),
        .Ksubs3_Noc16_RxData_cmd   (rx_cmd),
        .Ksubs3_Noc16_RxData_valid (rx_valid),
        .Ksubs3_Noc16_RxData_rdy   (rx_rdy),
        .Ksubs3_Noc16_TxData_lo    (tx_lo),
        .Ksubs3_Noc16_TxData_cmd   (tx_cmd),
        .Ksubs3_Noc16_TxData_valid (tx_valid),
        .Ksubs3_Noc16_TxData_rdy   (tx_rdy),
        .busy                      (busy)
`ifdef AES_DEC_ERR_EN
        ,
        .err_syndrome              (err_syndrome)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // FIPS byte 0 goes to the LSB
    function automatic logic [127:0] pack(input logic [127:0] f);
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[8*i +: 8] = f[127-8*i -: 8];
        return p;
    endfunction

    task automatic send(input logic [7:0] c, input logic [63:0] d);
        int n;
        n = 0;
        rx_cmd   = c;
        rx_lo    = d;
        rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rx_rdy) break;
            n++;
            if (n > 500) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_accept_timeout: got rdy=0, required rdy=1 (cmd %h)", c);
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic load_keys();
        logic [127:0] p;
        for (int r = 0; r < 11; r++) begin
            p = pack(KEY_FIPS[r]);
            send(8'd0, p[63:0]);
            send(8'd0, p[127:64]);
        end
    endtask

    task automatic load_iv_zero();
        send(8'd1, 64'h0);
        send(8'd1, 64'h0);
    endtask

    task automatic measure_latency(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!tx_valid && cyc < 100);
        chk(name, 64'(cyc), 64'd11);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while ((busy || tx_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("block_done", {62'b0, busy, tx_valid}, 64'd0);
    endtask

    // Monitor: every accepted plaintext beat is checked against the scoreboard
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (tx_valid && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx_beat", tx_lo, 64'h0);
                    n_vec++;
                    n_err++;
                    $display("FAIL tx_beat_unexpected: got beat %h, required none", tx_lo);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_lo", tx_lo, e);
                    chk("tx_cmd", {56'b0, tx_cmd}, 64'hFE);
                end
            end
        end
    end

    initial begin
        #2 reset = 1'b0;
        #1;
        chk("reset_rx_rdy", {63'b0, rx_rdy}, 64'd0);
        chk("reset_tx_valid", {63'b0, tx_valid}, 64'd0);
        chk("reset_tx_lo", tx_lo, 64'd0);
        chk("reset_tx_cmd", {56'b0, tx_cmd}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
`ifdef AES_DEC_ERR_EN
        chk("reset_err", {56'b0, err_syndrome}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_release", {63'b0, rx_rdy}, 64'd1);

        // Wrap: a full pass of junk keys, an unknown-cmd beat, then the real keys
        for (int i = 0; i < 22; i++) send(8'd0, 64'hdeadbeef00000000 | 64'(i));
        send(8'h07, 64'h0123456789abcdef);
`ifdef AES_DEC_ERR_EN
        chk("err_syndrome_07", {56'b0, err_syndrome}, 64'h07);
`endif
        load_keys();
        load_iv_zero();
        send(8'h33, 64'hfedcba9876543210);
`ifdef AES_DEC_ERR_EN
        chk("err_syndrome_33", {56'b0, err_syndrome}, 64'h33);
`endif

        // FIPS-197 C.1 with IV=0
        exp_q.push_back(PT_LO);
        exp_q.push_back(PT_HI);
        send(8'd2, CT_LO);
        send(8'd2, CT_HI);
        chk("rdy_drop_after_ct", {63'b0, rx_rdy}, 64'd0);
        measure_latency("latency_c1");
        wait_idle();

        // CBC chaining: same ciphertext, IV is now the previous ciphertext
        exp_q.push_back(CH_LO);
        exp_q.push_back(CH_HI);
        send(8'd2, CT_LO);
        send(8'd2, CT_HI);
        measure_latency("latency_chain");
        wait_idle();

        // Backpressure at TX_LO
        tx_rdy = 1'b0;
        exp_q.push_back(CH_LO);
        exp_q.push_back(CH_HI);
        send(8'd2, CT_LO);
        send(8'd2, CT_HI);
        measure_latency("latency_bp");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'b0, tx_valid}, 64'd1);
            chk("bp_lo", tx_lo, CH_LO);
            chk("bp_cmd", {56'b0, tx_cmd}, 64'hFE);
            chk("bp_rx_rdy", {63'b0, rx_rdy}, 64'd0);
            chk("bp_busy", {63'b0, busy}, 64'd1);
            @(posedge clk);
            #1;
        end
        tx_rdy = 1'b1;
        wait_idle();

        // Reset in the middle of the rounds (rnd=5)
        send(8'd2, CT_LO);
        send(8'd2, CT_HI);
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_rx_rdy", {63'b0, rx_rdy}, 64'd0);
        chk("midrst_tx_valid", {63'b0, tx_valid}, 64'd0);
        chk("midrst_tx_lo", tx_lo, 64'd0);
        chk("midrst_tx_cmd", {56'b0, tx_cmd}, 64'd0);
        chk("midrst_busy", {63'b0, busy}, 64'd0);
`ifdef AES_DEC_ERR_EN
        chk("midrst_err", {56'b0, err_syndrome}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        load_keys();
        load_iv_zero();
        exp_q.push_back(PT_LO);
        exp_q.push_back(PT_HI);
        send(8'd2, CT_LO);
        send(8'd2, CT_HI);
        measure_latency("latency_after_reset");
        wait_idle();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_cbc_decrypt_dev.md
Name: aes_cbc_decrypt_dev

Overview:
NOC16 peripheral performing iterative AES-128 CBC decryption. It is the receive-side counterpart of the CBC encryption peripheral and uses the same command codes, round-key load format and state byte packing. The host loads the 11 expanded round keys and the IV, then streams ciphertext in two 64-bit beats. The block returns plaintext in two 64-bit beats with a full valid/rdy handshake.

Parameters:
OUT_CMD, 8'hFE, cmd value driven on every plaintext beat
ROUNDS, 10, number of AES rounds; fixed for AES-128, not user-tunable

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
Ksubs3_Noc16_RxData_lo  input  64  inbound payload
Ksubs3_Noc16_RxData_cmd  input  8  inbound command: 0=round-key chunk, 1=IV chunk, 2=ciphertext chunk
Ksubs3_Noc16_RxData_valid  input  1  inbound beat valid
Ksubs3_Noc16_RxData_rdy  output  1  block can accept a beat
Ksubs3_Noc16_TxData_lo  output  64  plaintext half
Ksubs3_Noc16_TxData_cmd  output  8  OUT_CMD while valid
Ksubs3_Noc16_TxData_valid  output  1  outbound beat valid
Ksubs3_Noc16_TxData_rdy  input  1  sink accepts the beat
busy  output  1  high from ciphertext-complete until the hi beat is accepted

Behaviour:
- Reset values: RxData_rdy=0, TxData_valid=0, TxData_lo=0, TxData_cmd=0, busy=0. rk, iv, state and all indices are 0; FSM is in IDLE. RxData_rdy rises on the first clk edge after reset release.
- Beat accept: an inbound beat is accepted when RxData_valid && RxData_rdy on a rising edge. RxData_rdy=1 only in IDLE with fewer than 2 ciphertext beats buffered.
- cmd 0: stores chunk at rk[64*rk_idx+63:64*rk_idx]; rk_idx counts 0..21, then wraps to 0. Round key r = rk[128r+127:128r].
- cmd 1: stores iv[63:0] then iv[127:64]; the index wraps.
- cmd 2: first beat goes to ct[63:0], second to ct[127:64]. The second beat drops RxData_rdy on the same edge.
- Any other cmd: the beat is accepted and discarded.
- Byte packing: FIPS state byte 4c+r occupies bits [32c+8r+7:32c+8r], so FIPS byte 0 is the LSB.
- InvShiftRows: output word j, byte k = input word (j-k) mod 4, byte k. This is the exact inverse of the team's ShiftRows.
- InvMixColumns, per 32-bit word: out_k = 0e*b_k ^ 0b*b_(k+1) ^ 0d*b_(k+2) ^ 09*b_(k+3), indices mod 4, GF(2^8) with polynomial 0x11b.
- FSM IDLE -> ROUND -> TX_LO -> TX_HI -> IDLE:
  - IDLE, ct complete: state <= ct ^ rk10; rnd <= 9; busy <= 1.
  - ROUND, rnd 9..1: state <= InvMixCols(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]); rnd decrements.
  - ROUND, rnd 0: pt = InvSubBytes(InvShiftRows(state)) ^ rk0 ^ iv. Then iv <= ct, TxData_lo <= pt[63:0], TxData_cmd <= OUT_CMD, TxData_valid <= 1.
  - TX_LO: hold all Tx outputs stable until TxData_rdy. On accept, TxData_lo <= pt[127:64].
  - TX_HI: on accept, TxData_valid <= 0, TxData_cmd <= 0, busy <= 0, ct index <= 0, go to IDLE.
- Latency: TxData_valid rises on the 11th rising edge after the edge that accepts the second ciphertext beat, assuming no backpressure.
- Key/IV writes are impossible while busy because RxData_rdy=0. Host ordering therefore guarantees a stable rk/iv during a block.
- iv update happens only after a block is fully decrypted, so consecutive blocks chain per CBC.
- Reset mid-operation (any state): all outputs return to reset values immediately, the partial block is lost, and rk/iv are cleared.

Optional Feature:
Macro AES_DEC_ERR_EN.
- Defined: adds output err_syndrome [7:0]. On an accepted beat with an unknown cmd, err_syndrome <= cmd, and it is sticky. A further unknown cmd overwrites it. Reset value is 0. An unknown cmd with value 0 cannot occur, since 0 is valid.
- Not defined: the port is absent and unknown beats are silently dropped.

Test Plan:
- FIPS-197 C.1: load the expanded key of 000102..0f, IV=0, ct lo=64'h30047b6ad8e0c469, hi=64'h5ac5b47080b7cdd8. Required: plaintext lo=64'h7766554433221100, hi=64'hffeeddccbbaa9988, cmd 8'hFE, valid 11 edges after the ct hi accept.
- CBC chain: immediately resend the same ct block. Required: lo=64'h47622e2eebc2d569, hi=64'ha52b69bc3b1d5450 (pt ^ previous ct).
- Backpressure: hold TxData_rdy=0 for 5 cycles at TX_LO. Required: valid=1, lo/cmd stable, hi not driven, RxData_rdy=0, busy=1 throughout.
- Reset mid-ROUND, asserted at rnd=5: outputs go to 0 asynchronously. After release, reload keys/IV and run vector 1; it passes.
- Wrap: send 22 key chunks twice, second pass with the correct key. Required: C.1 result proves rk_idx wrapped to 0. Also check that a cmd 8'h07 beat is accepted without corrupting state.
- With AES_DEC_ERR_EN defined: send cmd 8'h07 and then 8'h33. Required: err_syndrome = 8'h07 and then 8'h33, and the decrypt result is unaffected.
